// File: rtl/cbus_arbiter_pkg.sv
// Shared types for the core bus arbiter: access size encoding, the cbus
// request/response bundles and the arbiter FSM state encoding.
package cbus_arbiter_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cbus_arbiter_starve_ctr.sv
// Saturating starvation counter for the fetch requester.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   inc        : count one dbus win while ibus was waiting
//   clr        : ibus granted or no ibus request pending (wins over inc)
//   at_limit   : counter has reached LIMIT, ibus must win next arbitration
module arb_starve_ctr #(
  parameter int LIMIT = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign at_limit = (cnt_q == CNT_W'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_limit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Core-side bus arbiter: shares one cbus between instruction fetch (ibus)
// and data memory (dbus). One whole cbus transaction is sequenced at a time
// and its final response is routed back to the owner.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   ireq_*             : fetch request (held until response or flush)
//   dreq_*             : data request (held until response)
//   iresp_*, dresp_*   : one-cycle response pulses with data
//   ibus/dbus_not_busy : stall hints for the pipeline
//   creq_*             : request toward the cache / uncached bus
//   cresp_*            : beats returned from the cache / uncached bus
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        iresp_ready,
  output logic [63:0] iresp_data,
  output logic        dresp_ready,
  output logic [63:0] dresp_data,
  output logic        ibus_not_busy,
  output logic        dbus_not_busy,
  output logic        creq_valid,
  output logic        creq_is_write,
  output logic [63:0] creq_addr,
  output logic [2:0]  creq_size,
  output logic [7:0]  creq_strobe,
  output logic [63:0] creq_data,
  input  logic        cresp_ready,
  input  logic        cresp_last,
  input  logic [63:0] cresp_data
);

  arb_state_t state_q, state_d;
  cbus_req_t  lat_q, lat_d;
  cbus_resp_t cresp;
  logic       abandoned_q, abandoned_d;
  logic       grant_i, grant_d, done, at_limit;

  assign cresp = '{ready: cresp_ready, last: cresp_last, data: cresp_data};
  assign done  = cresp.ready && cresp.last;

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (CNT_W)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (grant_d && ireq_valid),
    .clr      (grant_i || !ireq_valid),
    .at_limit (at_limit)
  );

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    abandoned_d = abandoned_q;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    iresp_ready = 1'b0;
    dresp_ready = 1'b0;
    case (state_q)
      IDLE: begin
        abandoned_d = 1'b0;
        // dbus has priority unless ibus has been passed over too often
        grant_i = ireq_valid && (!dreq_valid || at_limit);
        grant_d = dreq_valid && !grant_i;
        if (grant_i) begin
          state_d = BUSY_I;
          lat_d   = '{valid: 1'b1, is_write: 1'b0, addr: ireq_addr,
                      size: MSIZE4, strobe: 8'h00, data: 64'h0};
        end else if (grant_d) begin
          state_d = BUSY_D;
          lat_d   = '{valid: 1'b1, is_write: |dreq_strobe, addr: dreq_addr,
                      size: msize_t'(dreq_size), strobe: dreq_strobe,
                      data: dreq_data};
        end
      end
      BUSY_I: begin
        // a flushed fetch still drains on cbus, but nobody gets the data
        if (!ireq_valid) abandoned_d = 1'b1;
        iresp_ready = done && ireq_valid && !abandoned_q;
        if (done) begin
          state_d     = IDLE;
          lat_d.valid = 1'b0;
          abandoned_d = 1'b0;
        end
      end
      BUSY_D: begin
        dresp_ready = done;
        if (done) begin
          state_d     = IDLE;
          lat_d.valid = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        lat_d.valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      abandoned_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      abandoned_q <= abandoned_d;
    end
  end

  assign iresp_data    = iresp_ready ? cresp.data : 64'h0;
  assign dresp_data    = dresp_ready ? cresp.data : 64'h0;
  assign ibus_not_busy = !ireq_valid || iresp_ready;
  assign dbus_not_busy = !dreq_valid || dresp_ready;

  assign creq_valid    = lat_q.valid;
  assign creq_is_write = lat_q.is_write;
  assign creq_addr     = lat_q.addr;
  assign creq_size     = lat_q.size;
  assign creq_strobe   = lat_q.strobe;
  assign creq_data     = lat_q.data;

  // the data requester may not withdraw while its transaction is on cbus
  a_dreq_held: assert property (@(posedge clk) disable iff (reset)
    (state_q == BUSY_D) |-> dreq_valid);

endmodule

// File: tb/tb_cbus_arbiter.sv
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        iresp_ready;
  logic [63:0] iresp_data;
  logic        dresp_ready;
  logic [63:0] dresp_data;
  logic        ibus_not_busy;
  logic        dbus_not_busy;
  logic        creq_valid;
  logic        creq_is_write;
  logic [63:0] creq_addr;
  logic [2:0]  creq_size;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_data;
  logic        cresp_ready;
  logic        cresp_last;
  logic [63:0] cresp_data;

  int checks = 0;
  int errors = 0;

  cbus_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .iresp_ready   (iresp_ready),
    .iresp_data    (iresp_data),
    .dresp_ready   (dresp_ready),
    .dresp_data    (dresp_data),
    .ibus_not_busy (ibus_not_busy),
    .dbus_not_busy (dbus_not_busy),
    .creq_valid    (creq_valid),
    .creq_is_write (creq_is_write),
    .creq_addr     (creq_addr),
    .creq_size     (creq_size),
    .creq_strobe   (creq_strobe),
    .creq_data     (creq_data),
    .cresp_ready   (cresp_ready),
    .cresp_last    (cresp_last),
    .cresp_data    (cresp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic last, input logic [63:0] data);
    cresp_ready = 1'b1;
    cresp_last  = last;
    cresp_data  = data;
  endtask

  task automatic no_beat();
    cresp_ready = 1'b0;
    cresp_last  = 1'b0;
    cresp_data  = 64'h0;
  endtask

  initial begin
    reset = 1'b1;
    ireq_valid = 1'b0; ireq_addr = 64'h0;
    dreq_valid = 1'b0; dreq_addr = 64'h0; dreq_size = 3'd0;
    dreq_strobe = 8'h0; dreq_data = 64'h0;
    no_beat();
    #2;
    // reset state
    chk("rst_creq_valid", 64'(creq_valid), 64'd0);
    chk("rst_creq_addr", creq_addr, 64'h0);
    chk("rst_iresp_ready", 64'(iresp_ready), 64'd0);
    chk("rst_dresp_ready", 64'(dresp_ready), 64'd0);
    chk("rst_ibus_nb", 64'(ibus_not_busy), 64'd1);
    chk("rst_dbus_nb", 64'(dbus_not_busy), 64'd1);
    chk("rst_state", 64'(dut.state_q), 64'(IDLE));
    tick(); tick();
    reset = 1'b0;

    // 1: lone fetch, single beat after 2 cycles
    tick();
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0000;
    #1;
    chk("t1_idle_nb", 64'(ibus_not_busy), 64'd0);
    chk("t1_idle_valid", 64'(creq_valid), 64'd0);
    tick();
    chk("t1_creq_valid", 64'(creq_valid), 64'd1);
    chk("t1_creq_addr", creq_addr, 64'h8000_0000);
    chk("t1_creq_size", 64'(creq_size), 64'(MSIZE4));
    chk("t1_creq_strobe", 64'(creq_strobe), 64'h0);
    chk("t1_creq_wr", 64'(creq_is_write), 64'd0);
    tick();
    chk("t1_wait_resp", 64'(iresp_ready), 64'd0);
    tick();
    beat(1'b1, 64'h13);
    #1;
    chk("t1_iresp_ready", 64'(iresp_ready), 64'd1);
    chk("t1_iresp_data", iresp_data, 64'h13);
    chk("t1_ibus_nb", 64'(ibus_not_busy), 64'd1);
    tick();
    no_beat(); ireq_valid = 1'b0;
    #1;
    chk("t1_iresp_once", 64'(iresp_ready), 64'd0);
    chk("t1_state_idle", 64'(dut.state_q), 64'(IDLE));
    chk("t1_creq_drop", 64'(creq_valid), 64'd0);

    // 2: simultaneous requests, dbus first, ibus after one IDLE cycle
    tick();
    ireq_valid = 1'b1; ireq_addr = 64'h1000;
    dreq_valid = 1'b1; dreq_addr = 64'h2000; dreq_size = 3'd3;
    dreq_strobe = 8'hFF; dreq_data = 64'hDEAD;
    tick();
    chk("t2_state_d", 64'(dut.state_q), 64'(BUSY_D));
    chk("t2_creq_wr", 64'(creq_is_write), 64'd1);
    chk("t2_creq_addr", creq_addr, 64'h2000);
    chk("t2_creq_data", creq_data, 64'hDEAD);
    chk("t2_creq_strobe", 64'(creq_strobe), 64'hFF);
    chk("t2_creq_size", 64'(creq_size), 64'd3);
    chk("t2_starve1", 64'(dut.u_starve.cnt_q), 64'd1);
    beat(1'b1, 64'h0);
    #1;
    chk("t2_dresp", 64'(dresp_ready), 64'd1);
    chk("t2_no_iresp", 64'(iresp_ready), 64'd0);
    tick();
    no_beat(); dreq_valid = 1'b0; dreq_strobe = 8'h0;
    #1;
    chk("t2_gap_idle", 64'(dut.state_q), 64'(IDLE));
    chk("t2_gap_valid", 64'(creq_valid), 64'd0);
    tick();
    chk("t2_state_i", 64'(dut.state_q), 64'(BUSY_I));
    chk("t2_i_addr", creq_addr, 64'h1000);
    chk("t2_i_wr", 64'(creq_is_write), 64'd0);
    chk("t2_starve0", 64'(dut.u_starve.cnt_q), 64'd0);
    beat(1'b1, 64'h77);
    #1;
    chk("t2_iresp_data", iresp_data, 64'h77);
    tick();
    no_beat(); ireq_valid = 1'b0;

    // 3: starvation limit forces ibus on the 5th arbitration
    tick();
    ireq_valid = 1'b1; ireq_addr = 64'h3000;
    dreq_valid = 1'b1; dreq_addr = 64'h4000; dreq_size = 3'd3; dreq_data = 64'h0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t3_state_d", 64'(dut.state_q), 64'(BUSY_D));
      chk("t3_starve", 64'(dut.u_starve.cnt_q), 64'(k));
      beat(1'b1, 64'(k));
      #1;
      chk("t3_dresp_data", dresp_data, 64'(k));
      tick();
      no_beat();
    end
    tick();
    chk("t3_state_i", 64'(dut.state_q), 64'(BUSY_I));
    chk("t3_i_addr", creq_addr, 64'h3000);
    chk("t3_starve_clr", 64'(dut.u_starve.cnt_q), 64'd0);
    dreq_valid = 1'b0;
    beat(1'b1, 64'h33);
    #1;
    chk("t3_iresp", 64'(iresp_ready), 64'd1);
    tick();
    no_beat(); ireq_valid = 1'b0;

    // 4: fetch flushed one cycle into BUSY_I
    tick();
    ireq_valid = 1'b1; ireq_addr = 64'h5000;
    tick();
    chk("t4_state_i", 64'(dut.state_q), 64'(BUSY_I));
    tick();
    ireq_valid = 1'b0;
    dreq_valid = 1'b1; dreq_addr = 64'h6000; dreq_size = 3'd2;
    dreq_strobe = 8'h0F; dreq_data = 64'h55;
    tick();
    chk("t4_hold_valid", 64'(creq_valid), 64'd1);
    chk("t4_abandoned", 64'(dut.abandoned_q), 64'd1);
    beat(1'b1, 64'h99);
    #1;
    chk("t4_no_iresp", 64'(iresp_ready), 64'd0);
    chk("t4_no_dresp", 64'(dresp_ready), 64'd0);
    chk("t4_valid_last", 64'(creq_valid), 64'd1);
    tick();
    no_beat();
    #1;
    chk("t4_idle", 64'(dut.state_q), 64'(IDLE));
    chk("t4_abandon_clr", 64'(dut.abandoned_q), 64'd0);
    tick();
    chk("t4_state_d", 64'(dut.state_q), 64'(BUSY_D));
    chk("t4_d_addr", creq_addr, 64'h6000);
    chk("t4_d_wr", 64'(creq_is_write), 64'd1);
    beat(1'b1, 64'h0);
    #1;
    chk("t4_dresp", 64'(dresp_ready), 64'd1);
    tick();
    no_beat(); dreq_valid = 1'b0; dreq_strobe = 8'h0;

    // 5: four-beat response, only the last ends it
    tick();
    dreq_valid = 1'b1; dreq_addr = 64'h7000; dreq_size = 3'd3;
    tick();
    for (int b = 1; b <= 3; b++) begin
      beat(1'b0, 64'h100 + 64'(b));
      #1;
      chk("t5_mid_dresp", 64'(dresp_ready), 64'd0);
      chk("t5_mid_nb", 64'(dbus_not_busy), 64'd0);
      tick();
    end
    beat(1'b1, 64'h104);
    #1;
    chk("t5_last_dresp", 64'(dresp_ready), 64'd1);
    chk("t5_last_data", dresp_data, 64'h104);
    tick();
    no_beat(); dreq_valid = 1'b0;
    #1;
    chk("t5_idle", 64'(dut.state_q), 64'(IDLE));

    // 6: reset pulse between edges while BUSY_D
    tick();
    dreq_valid = 1'b1; dreq_addr = 64'h8000; dreq_size = 3'd1; dreq_strobe = 8'h03;
    tick();
    chk("t6_busy_valid", 64'(creq_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(creq_valid), 64'd0);
    chk("t6_rst_state", 64'(dut.state_q), 64'(IDLE));
    chk("t6_rst_addr", creq_addr, 64'h0);
    chk("t6_rst_strobe", 64'(creq_strobe), 64'h0);
    chk("t6_rst_wr", 64'(creq_is_write), 64'd0);
    chk("t6_rst_dresp", 64'(dresp_ready), 64'd0);
    dreq_valid = 1'b0; dreq_strobe = 8'h0;
    #1;
    chk("t6_rst_dbus_nb", 64'(dbus_not_busy), 64'd1);
    tick();
    reset = 1'b0;
    tick();
    ireq_valid = 1'b1; ireq_addr = 64'h9000;
    tick();
    chk("t6_fresh_addr", creq_addr, 64'h9000);
    beat(1'b1, 64'hABC);
    #1;
    chk("t6_fresh_iresp", 64'(iresp_ready), 64'd1);
    chk("t6_fresh_data", iresp_data, 64'hABC);
    tick();
    no_beat(); ireq_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
